// File: rtl/mux8x1_using_4x1.sv
// 8-to-1 lane selector with a registered output.
// Structure: two 4-to-1 stages pick within lanes 0-3 and lanes 4-7.
// A final 2-to-1 cell chooses between the two stage results on sel[2].
// Lane k of the packed input occupies in[k*WIDTH +: WIDTH].

// 2-to-1 cell: returns b when sel is high, otherwise a.
module mux2_cell #(
   parameter int unsigned WIDTH = 1
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   output logic [WIDTH-1:0] out
);

   assign out = sel ? b : a;

endmodule

// 4-to-1 stage: two 2-to-1 cells on sel[0], then one 2-to-1 cell on sel[1].
module mux4_stage #(
   parameter int unsigned WIDTH = 1
) (
   input  logic [4*WIDTH-1:0] in,
   input  logic [1:0]         sel,
   output logic [WIDTH-1:0]   out
);

   logic [WIDTH-1:0] pair_01;
   logic [WIDTH-1:0] pair_23;

   mux2_cell #(.WIDTH(WIDTH)) u_pair_01 (
      .a   (in[0*WIDTH +: WIDTH]),
      .b   (in[1*WIDTH +: WIDTH]),
      .sel (sel[0]),
      .out (pair_01)
   );

   mux2_cell #(.WIDTH(WIDTH)) u_pair_23 (
      .a   (in[2*WIDTH +: WIDTH]),
      .b   (in[3*WIDTH +: WIDTH]),
      .sel (sel[0]),
      .out (pair_23)
   );

   mux2_cell #(.WIDTH(WIDTH)) u_pair_sel (
      .a   (pair_01),
      .b   (pair_23),
      .sel (sel[1]),
      .out (out)
   );

endmodule

// Top: combinational select tree feeding the single output register.
module mux8x1_using_4x1 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [8*WIDTH-1:0] in,
   input  logic [2:0]         sel,
   output logic [WIDTH-1:0]   out
);

   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] sel_lane;

   mux4_stage #(.WIDTH(WIDTH)) u_lo (
      .in  (in[4*WIDTH-1:0]),
      .sel (sel[1:0]),
      .out (lo)
   );

   mux4_stage #(.WIDTH(WIDTH)) u_hi (
      .in  (in[8*WIDTH-1:4*WIDTH]),
      .sel (sel[1:0]),
      .out (hi)
   );

   mux2_cell #(.WIDTH(WIDTH)) u_final (
      .a   (lo),
      .b   (hi),
      .sel (sel[2]),
      .out (sel_lane)
   );

   // Output register: synchronous clear has priority over loading the selected lane.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignment keeps the register update race-free against
      // every other process sampling on the same edge.
      if (rst) begin
         out <= '0;
      end else begin
         out <= sel_lane;
      end
   end

endmodule

// File: tb/tb_mux8x1_using_4x1.sv
// Scoreboard bench for mux8x1_using_4x1: a WIDTH=1 and a WIDTH=4 instance
// share rst and sel. The driver queues hand-computed expectations at each
// rising edge; the monitor pops and compares them on the following falling edge.
module tb_mux8x1_using_4x1;

   logic        clk;
   logic        rst;
   logic [2:0]  sel;
   logic [7:0]  in1;
   logic [31:0] in4;
   logic        out1;
   logic [3:0]  out4;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic       e1;
      logic [3:0] e4;
      string      name;
   } exp_t;

   exp_t sb[$];

   mux8x1_using_4x1 #(.WIDTH(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .in  (in1),
      .sel (sel),
      .out (out1)
   );

   mux8x1_using_4x1 #(.WIDTH(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .in  (in4),
      .sel (sel),
      .out (out4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: output is presented every cycle, so compare one entry per falling edge.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check({e.name, "_w1"}, {31'd0, out1}, {31'd0, e.e1});
         check({e.name, "_w4"}, {28'd0, out4}, {28'd0, e.e4});
      end
   end

   // Drive one vector away from the active edge, then queue what that edge must produce.
   task automatic step(input logic r, input logic [2:0] s, input logic [7:0] i1,
                       input logic [31:0] i4, input logic e1, input logic [3:0] e4,
                       input string nm);
      @(negedge clk);
      rst = r;
      sel = s;
      in1 = i1;
      in4 = i4;
      @(posedge clk);
      sb.push_back('{e1: e1, e4: e4, name: nm});
   endtask

   // Sweep results for in=8'b10110011, sel=0..7, worked out by hand.
   logic sweep_exp [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

   initial begin
      rst = 1'b0;
      sel = 3'd0;
      in1 = 8'h00;
      in4 = 32'h0;

      // Reset with every lane high and the top lane selected.
      step(1'b1, 3'd7, 8'hFF, 32'hFFFF_FFFF, 1'b0, 4'h0, "rst_edge1");
      step(1'b1, 3'd7, 8'hFF, 32'hFFFF_FFFF, 1'b0, 4'h0, "rst_edge2");
      step(1'b0, 3'd7, 8'hFF, 32'hFFFF_FFFF, 1'b1, 4'hF, "rst_release");

      // Full sweep; the wide instance returns its own lane index.
      for (int s = 0; s < 8; s++) begin
         step(1'b0, 3'(s), 8'b1011_0011, 32'h7654_3210, sweep_exp[s], 4'(s),
              $sformatf("sweep_sel%0d", s));
      end

      // Lane isolation: one hot lane, every select code.
      for (int k = 0; k < 8; k++) begin
         for (int s = 0; s < 8; s++) begin
            step(1'b0, 3'(s), 8'(1 << k), 32'hF << (4 * k),
                 (s == k), (s == k) ? 4'hF : 4'h0,
                 $sformatf("onehot_k%0d_sel%0d", k, s));
         end
      end

      // Latency: lane 0 changes just after an edge and glitches before the next one.
      step(1'b0, 3'd0, 8'h00, 32'h0, 1'b0, 4'h0, "lat_hold");
      #1 in1 = 8'h01; in4 = 32'h5;
      #2 in1 = 8'h00; in4 = 32'h0;
      #2 in1 = 8'h01; in4 = 32'h5;
      @(posedge clk);
      sb.push_back('{e1: 1'b1, e4: 4'h5, name: "lat_update"});

      // Mid-operation reset during a sweep, then resume.
      step(1'b0, 3'd0, 8'b1011_0011, 32'h7654_3210, 1'b1, 4'h0, "mid_pre0");
      step(1'b0, 3'd1, 8'b1011_0011, 32'h7654_3210, 1'b1, 4'h1, "mid_pre1");
      step(1'b1, 3'd4, 8'b1011_0011, 32'h7654_3210, 1'b0, 4'h0, "mid_rst");
      step(1'b0, 3'd4, 8'b1011_0011, 32'h7654_3210, 1'b1, 4'h4, "mid_resume4");
      step(1'b0, 3'd7, 8'b1011_0011, 32'h7654_3210, 1'b1, 4'h7, "mid_resume7");

      // Width: a scrambled wide pattern checks lane ordering beyond identity values.
      step(1'b0, 3'd2, 8'h04, 32'hA5C3_0F96, 1'b1, 4'hF, "wide_sel2");
      step(1'b0, 3'd6, 8'h40, 32'hA5C3_0F96, 1'b1, 4'h5, "wide_sel6");

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
      #1;
      n_checks++;
      if (sb.size() != 0) begin
         n_errors++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mux8x1_using_4x1.md
Name: mux8x1_using_4x1

Overview:
- 8-to-1 selector: one of eight input lanes, chosen by a 3-bit select, drives a registered output.
- Built hierarchically:
  - two 4-to-1 stages, each built from 2-to-1 cells, select within the lower lanes (0-3) and the upper lanes (4-7);
  - a final 2-to-1 stage picks between the two stage results.
- Used as a generic datapath/bit selector. The select tree is combinational; the output is registered on the single clock.

Parameters:
WIDTH, 1, bit width of each input lane and of out; lane k occupies in[k*WIDTH +: WIDTH]

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
in  input  8*WIDTH  eight packed lanes, lane 0 in least-significant position
sel  input  3  lane select, 0..7
out  output  WIDTH  registered selected lane

Behaviour:
- Reset is sampled only on a rising clk edge.
  - rst=1 at an edge: out <= 0, all bits.
  - rst has priority over any data update in the same cycle.
  - Reset asserted mid-operation clears out at the next edge, regardless of in/sel.
- Select tree (combinational, no state):
  - lo = lane[sel[1:0]] of lanes 0-3; hi = lane[sel[1:0]] of lanes 4-7.
  - Each 4-to-1 stage is two 2-to-1 cells on sel[0] followed by a 2-to-1 cell on sel[1].
  - Result = sel[2] ? hi : lo, i.e. lane[sel].
- Register: on each rising edge with rst=0, out <= lane[sel] sampled at that edge.
- Latency is exactly 1 clock from in/sel to out.
- Changes to in or sel between edges have no effect on out until the next edge.
- No enable, no handshake. out updates every non-reset cycle.
- All 8 sel codes are valid; there is no out-of-range case.
- Any in bits outside the selected lane never affect out.
- No internal state other than the out register.
- Hierarchy:
  - the 2-to-1 cell and the 4-to-1 stage are separate submodules, both parameterized by WIDTH;
  - the top instantiates two 4-to-1 stages and one 2-to-1 cell.
- After power-up and before the first reset, out is undefined. Benches must apply reset before checking.

Test Plan:
- Reset: rst=1 for 2 edges with in=8'hFF, sel=3'd7 -> out=0 after the first edge. rst=0 -> out=1 after the next edge.
- Full sweep: WIDTH=1, in=8'b10110011, sel stepped 0..7, one value per edge, checked one edge later -> out = 1,1,0,0,1,1,0,1. Each value equals in[sel].
- Lane isolation: in=one-hot 1<<k, for each k sweep all sel -> out=1 only when sel==k, else 0. Confirms no cross-lane leakage between the lower and upper 4-to-1 stages.
- Latency: sel=0 with in[0]=0, then in[0]=1 changed just after an edge -> out stays 0 for that cycle and becomes 1 at the following edge. Toggling in between edges causes no out glitch.
- Mid-operation reset: sweep in progress with out=1, assert rst for one edge -> out=0 that edge. Deassert -> out resumes lane[sel] at the next edge.
- Width: WIDTH=4, in=32'h7654_3210, sel 0..7 -> out = 4'h0..4'h7 respectively.
